// File: rtl/parking_exit.sv
// rtl/parking_exit.sv - exit-gate controller: coin payment with change/refund, gate hold, occupancy count
module parking_exit #(
    parameter logic [3:0]  CAPACITY      = 4'd8,
    parameter logic [3:0]  EXIT_FEE      = 4'd5,
    parameter logic [15:0] TIMEOUT_LIMIT = 16'd10000,
    parameter logic [15:0] GATE_HOLD     = 16'd2000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       exit_sensor,
    input  logic       car_passed,
    input  logic       car_entered,
    input  logic       coin_valid,
    input  logic [3:0] coin_value,
    output logic       exit_gate,
    output logic       change_valid,
    output logic [4:0] change_value,
    output logic [3:0] occupancy,
    output logic       full,
    output logic [6:0] display
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PAYMENT   = 2'd1,
        GATE_OPEN = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [4:0]  r_paid;
    logic [4:0]  w_paid_next;
    logic [15:0] r_timer;
    logic [15:0] w_timer_next;
    logic [3:0]  r_occupancy;
    logic        r_change_valid;
    logic [4:0]  r_change_value;
    logic        w_chg_valid;
    logic [4:0]  w_chg_value;
    logic        w_dec;
    logic [4:0]  w_sum;
    logic [4:0]  w_held;
    logic [3:0]  w_owed;

    // paid never exceeds EXIT_FEE-1 (<=14), so paid + coin (<=29) fits in 5 bits
    assign w_sum  = r_paid + {1'b0, coin_value};
    assign w_held = coin_valid ? w_sum : r_paid;
    assign w_owed = EXIT_FEE - r_paid[3:0];

    always_comb begin
        w_state_next = r_state;
        w_paid_next  = r_paid;
        w_timer_next = r_timer;
        w_chg_valid  = 1'b0;
        w_chg_value  = 5'd0;
        w_dec        = 1'b0;
        case (r_state)
            IDLE: begin
                if (exit_sensor && (r_occupancy != 4'd0)) begin
                    w_state_next = PAYMENT;
                    w_paid_next  = 5'd0;
                    w_timer_next = 16'd0;
                end
            end
            PAYMENT: begin
                w_timer_next = r_timer + 16'd1;
                if (coin_valid && (w_sum >= {1'b0, EXIT_FEE})) begin
                    w_state_next = GATE_OPEN;
                    w_chg_valid  = 1'b1;
                    w_chg_value  = w_sum - {1'b0, EXIT_FEE};
                    w_timer_next = 16'd0;
                    w_paid_next  = 5'd0;
                end else if (r_timer == TIMEOUT_LIMIT) begin
                    // refund includes a non-completing coin accepted on the timeout cycle
                    w_state_next = IDLE;
                    w_paid_next  = 5'd0;
                    w_chg_valid  = (w_held != 5'd0);
                    w_chg_value  = w_held;
                end else begin
                    w_paid_next = w_held;
                end
            end
            GATE_OPEN: begin
                w_timer_next = r_timer + 16'd1;
                if (car_passed) begin
                    w_state_next = IDLE;
                    w_dec        = 1'b1;
                end else if (r_timer == GATE_HOLD) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= IDLE;
            r_paid         <= 5'd0;
            r_timer        <= 16'd0;
            r_change_valid <= 1'b0;
            r_change_value <= 5'd0;
        end else begin
            r_state        <= w_state_next;
            r_paid         <= w_paid_next;
            r_timer        <= w_timer_next;
            r_change_valid <= w_chg_valid;
            r_change_value <= w_chg_value;
        end
    end

    // an entry and an exit on the same edge cancel, even when full
    always_ff @(posedge clock) begin
        if (reset) begin
            r_occupancy <= 4'd0;
        end else if (car_entered && w_dec) begin
            r_occupancy <= r_occupancy;
        end else if (car_entered && (r_occupancy != CAPACITY)) begin
            r_occupancy <= r_occupancy + 4'd1;
        end else if (w_dec && (r_occupancy != 4'd0)) begin
            r_occupancy <= r_occupancy - 4'd1;
        end
    end

    assign exit_gate    = (r_state == GATE_OPEN);
    assign change_valid = r_change_valid;
    assign change_value = r_change_value;
    assign occupancy    = r_occupancy;
    assign full         = (r_occupancy == CAPACITY);
    assign display      = (r_state == PAYMENT) ? {3'b000, w_owed} : 7'b1111111;

endmodule

// File: tb/tb_parking_exit.sv
// tb/tb_parking_exit.sv - directed bench with a cycle-level reference model for parking_exit
module tb_parking_exit;

    localparam int CAP   = 8;
    localparam int FEE   = 5;
    localparam int LIMIT = 10000;
    localparam int HOLD  = 2000;

    logic       clock = 1'b0;
    logic       reset;
    logic       exit_sensor;
    logic       car_passed;
    logic       car_entered;
    logic       coin_valid;
    logic [3:0] coin_value;
    logic       exit_gate;
    logic       change_valid;
    logic [4:0] change_value;
    logic [3:0] occupancy;
    logic       full;
    logic [6:0] display;

    int n_checks = 0;
    int n_errors = 0;

    parking_exit dut (
        .clock       (clock),
        .reset       (reset),
        .exit_sensor (exit_sensor),
        .car_passed  (car_passed),
        .car_entered (car_entered),
        .coin_valid  (coin_valid),
        .coin_value  (coin_value),
        .exit_gate   (exit_gate),
        .change_valid(change_valid),
        .change_value(change_value),
        .occupancy   (occupancy),
        .full        (full),
        .display     (display)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: "phase" 0 = waiting, 1 = collecting coins, 2 = gate up.
    int m_phase = 0;
    int m_paid  = 0;
    int m_age   = 0;
    int m_cars  = 0;
    int m_chg   = 0;
    int m_chg_v = 0;

    always @(posedge clock) begin
        int coin;
        int total;
        bit leaving;
        coin    = coin_valid ? int'(coin_value) : 0;
        leaving = 1'b0;
        if (reset) begin
            m_phase = 0; m_paid = 0; m_age = 0; m_cars = 0; m_chg = 0; m_chg_v = 0;
        end else begin
            m_chg = 0; m_chg_v = 0;
            if (m_phase == 0) begin
                if (exit_sensor && m_cars > 0) begin
                    m_phase = 1; m_paid = 0; m_age = 0;
                end
            end else if (m_phase == 1) begin
                total = m_paid + coin;
                if (coin_valid && total >= FEE) begin
                    m_chg = 1; m_chg_v = total - FEE; m_phase = 2; m_age = 0;
                end else if (m_age == LIMIT) begin
                    m_phase = 0;
                    if (total > 0) begin m_chg = 1; m_chg_v = total; end
                end else begin
                    m_paid = total; m_age++;
                end
            end else begin
                if (car_passed) begin
                    m_phase = 0; leaving = 1'b1;
                end else if (m_age == HOLD) begin
                    m_phase = 0;
                end else begin
                    m_age++;
                end
            end
            if (!(car_entered && leaving)) begin
                if (car_entered) m_cars = (m_cars < CAP) ? m_cars + 1 : CAP;
                else if (leaving) m_cars = (m_cars > 0) ? m_cars - 1 : 0;
            end
        end
        #1;
        chk("cyc_gate",  exit_gate, (m_phase == 2) ? 1 : 0);
        chk("cyc_cv",    change_valid, m_chg);
        chk("cyc_cval",  change_value, m_chg_v);
        chk("cyc_occ",   occupancy, m_cars);
        chk("cyc_full",  full, (m_cars == CAP) ? 1 : 0);
        chk("cyc_disp",  display, (m_phase == 1) ? (FEE - m_paid) : 127);
    end

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic coin(input int v);
        coin_valid = 1'b1; coin_value = 4'(v);
        cyc();
        coin_valid = 1'b0; coin_value = 4'd0;
    endtask

    task automatic enter_cars(input int n);
        for (int k = 0; k < n; k++) begin
            car_entered = 1'b1; cyc(); car_entered = 1'b0; cyc();
        end
    endtask

    task automatic arrive();
        exit_sensor = 1'b1; cyc(); exit_sensor = 1'b0;
    endtask

    initial begin
        int seen;
        int val;
        int n;
        reset = 1'b1; exit_sensor = 1'b0; car_passed = 1'b0; car_entered = 1'b0;
        coin_valid = 1'b0; coin_value = 4'd0;
        cyc(); cyc();
        chk("rst_gate", exit_gate, 0);
        chk("rst_cv", change_valid, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_disp", display, 127);
        reset = 1'b0;

        exit_sensor = 1'b1; cyc(); cyc(); exit_sensor = 1'b0;
        chk("empty_sensor_disp", display, 127);
        chk("empty_sensor_gate", exit_gate, 0);

        enter_cars(3);
        chk("entry_occ", occupancy, 3);
        arrive();
        chk("pay_disp0", display, 5);
        coin(2);
        chk("pay_disp1", display, 3);
        coin(3);
        chk("exact_cv", change_valid, 1);
        chk("exact_cval", change_value, 0);
        chk("exact_gate", exit_gate, 1);
        cyc();
        chk("exact_cv_once", change_valid, 0);
        car_passed = 1'b1; cyc(); car_passed = 1'b0;
        chk("passed_occ", occupancy, 2);
        chk("passed_gate", exit_gate, 0);

        arrive();
        coin(4);
        chk("over_disp", display, 1);
        coin(9);
        chk("over_cv", change_valid, 1);
        chk("over_cval", change_value, 8);
        cyc();
        chk("over_cv_once", change_valid, 0);
        car_passed = 1'b1; cyc(); car_passed = 1'b0;
        chk("over_occ", occupancy, 1);

        arrive();
        coin(3);
        chk("to_disp", display, 2);
        seen = 0; val = 0;
        for (int i = 0; i < LIMIT + 100 && seen == 0; i++) begin
            cyc();
            if (change_valid) begin seen = 1; val = int'(change_value); end
        end
        chk("to_seen", seen, 1);
        chk("to_refund", val, 3);
        chk("to_disp_idle", display, 127);
        chk("to_occ", occupancy, 1);

        arrive();
        coin(5);
        chk("hold_gate", exit_gate, 1);
        chk("hold_cval", change_value, 0);
        n = 0;
        while (exit_gate && n < HOLD + 100) begin n++; cyc(); end
        chk("hold_cycles", n, HOLD + 1);
        chk("hold_occ", occupancy, 1);

        reset = 1'b1; cyc(); reset = 1'b0;
        enter_cars(9);
        chk("cap_occ", occupancy, 8);
        chk("cap_full", full, 1);
        arrive();
        coin(5);
        car_entered = 1'b1; car_passed = 1'b1; cyc();
        car_entered = 1'b0; car_passed = 1'b0;
        chk("simul_occ", occupancy, 8);
        chk("simul_gate", exit_gate, 0);

        arrive();
        coin(4);
        chk("rstpay_disp", display, 1);
        reset = 1'b1; cyc(); reset = 1'b0;
        chk("rstpay_cv", change_valid, 0);
        chk("rstpay_disp_idle", display, 127);
        chk("rstpay_occ", occupancy, 0);

        coin(7);
        chk("idle_coin_cv", change_valid, 0);

        enter_cars(1);
        arrive();
        seen = 0; n = 0;
        while (display != 7'd127 && n < LIMIT + 100) begin
            if (change_valid) seen = 1;
            n++; cyc();
        end
        if (change_valid) seen = 1;
        chk("to_zero_done", (display == 7'd127) ? 1 : 0, 1);
        chk("to_zero_nopulse", seen, 0);
        cyc();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/parking_exit.md
PARKING_EXIT -- requirements
Module: parking_exit

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter CAPACITY, default 4'd8, the maximum occupancy count.
REQ-002 The block SHALL have parameter EXIT_FEE, default 4'd5, the fee in coin units; legal range 1..15.
REQ-003 The block SHALL have parameter TIMEOUT_LIMIT, default 16'd10000, the payment timeout in cycles.
REQ-004 The block SHALL have parameter GATE_HOLD, default 16'd2000, the maximum exit-gate open time in cycles.

Ports (name, direction, width, meaning):
REQ-005 clock  input  1  single clock; all state changes on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 exit_sensor  input  1  a car is waiting at the exit gate.
REQ-008 car_passed  input  1  a car has cleared the exit gate (level, sampled each cycle).
REQ-009 car_entered  input  1  one-cycle pulse from the entrance side when a car enters.
REQ-010 coin_valid  input  1  coin_value is valid this cycle.
REQ-011 coin_value  input  4  value of the inserted coin, 0..15.
REQ-012 exit_gate  output  1  exit gate open command.
REQ-013 change_valid  output  1  one-cycle pulse; change_value is valid.
REQ-014 change_value  output  5  change or refund amount.
REQ-015 occupancy  output  4  number of cars inside.
REQ-016 full  output  1  high when occupancy == CAPACITY.
REQ-017 display  output  7  amount still owed, or blank.

Function
REQ-018 The FSM SHALL have the states IDLE, PAYMENT and GATE_OPEN, encoded in 2 bits; exit_gate SHALL equal 1 only in GATE_OPEN (Moore output).
REQ-019 IDLE: when exit_sensor==1 and occupancy!=0, the FSM SHALL move to PAYMENT and clear paid (5 bit) and timer (16 bit); when occupancy==0, exit_sensor SHALL be ignored.
REQ-020 PAYMENT: on coin_valid, sum = paid + coin_value (5-bit, no overflow).
REQ-021 If sum >= EXIT_FEE, then at that edge the FSM SHALL enter GATE_OPEN, pulse change_valid for exactly one cycle with change_value = sum - EXIT_FEE (including 0), and clear timer.
REQ-022 If sum < EXIT_FEE, then paid SHALL be set to sum and the FSM SHALL stay in PAYMENT.
REQ-023 timer SHALL increment every cycle in PAYMENT; when timer == TIMEOUT_LIMIT and no coin completes payment that cycle, the FSM SHALL return to IDLE; if paid (plus any coin accepted that cycle) is nonzero, it SHALL pulse change_valid with change_value = that refund amount.
REQ-024 A coin that completes payment SHALL take priority over a timeout in the same cycle.
REQ-025 Dropping exit_sensor in PAYMENT SHALL NOT abort the transaction.
REQ-026 GATE_OPEN: timer SHALL increment every cycle.
REQ-027 In GATE_OPEN, car_passed==1 SHALL decrement occupancy and return the FSM to IDLE.
REQ-028 In GATE_OPEN, when timer == GATE_HOLD without car_passed, the FSM SHALL return to IDLE with occupancy unchanged; the fee is forfeited.
REQ-029 Coins outside PAYMENT SHALL be ignored, with no change pulse.
REQ-030 occupancy: car_entered SHALL increment it, saturating at CAPACITY; a decrement SHALL never go below 0.
REQ-031 A simultaneous increment and decrement SHALL leave occupancy unchanged.
REQ-032 display SHALL be {3'b000, EXIT_FEE - paid} in PAYMENT and 7'b1111111 otherwise (combinational).

Reset
REQ-033 On reset==1 at a rising edge, the block SHALL set state=IDLE, paid=0, timer=0, occupancy=0, exit_gate=0, change_valid=0, change_value=0; full=0 and display=7'b1111111 follow from that state.
REQ-034 Reset SHALL override all other inputs, including mid-PAYMENT, where paid is discarded with no refund pulse.
REQ-035 Reset SHALL be sampled only on rising clock edges; it SHALL have no asynchronous effect.

Verification
REQ-036 Entry, then exact fee: 3 car_entered pulses -> occupancy=3; exit_sensor; coins 2,3 -> GATE_OPEN; change_valid with change_value=0; car_passed -> occupancy=2, IDLE.
REQ-037 Overpay: coins 4,9 with EXIT_FEE=5 -> change_value=8 for one cycle; display shows 1 after the first coin.
REQ-038 Timeout: one coin of 3, then no further coins -> return to IDLE when timer reaches TIMEOUT_LIMIT; change_value=3 refund; occupancy unchanged.
REQ-039 Boundaries: exit_sensor with occupancy=0 -> stays in IDLE; 9 car_entered pulses with CAPACITY=8 -> occupancy=8, full=1; car_entered coincident with car_passed -> occupancy unchanged.
REQ-040 Gate hold: GATE_OPEN with no car_passed for GATE_HOLD cycles -> exit_gate drops; occupancy unchanged.
REQ-041 Reset mid-PAYMENT with paid=4 -> next cycle in IDLE, change_valid=0, occupancy=0.
